// File: rtl/alu_pkg.sv
// Shared types and helpers for the slice-serial ALU: opcode and FSM encodings,
// plus the per-op classification used by both the slice and the sequencer.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_ADC    = 3'b001,
        OP_SUB    = 3'b010,
        OP_CMP    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110,
        OP_PASS_B = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

    // Carry fed into slice 0: SUB/CMP form A + ~B + 1, ADC takes the caller's carry.
    function automatic logic init_carry(input op_e op, input logic cin);
        case (op)
            OP_ADC:         return cin;
            OP_SUB, OP_CMP: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU cell; ripple carry with the carry into the MSB
// exported so the sequencer can derive signed overflow on the last slice.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  op_e              op,
    output logic [SLICE-1:0] y,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] w_b_eff;
    logic [SLICE-1:0] w_sum;
    logic [SLICE:0]   w_c;

    always_comb begin
        w_b_eff = ((op == OP_SUB) || (op == OP_CMP)) ? ~b : b;
        w_sum   = '0;
        w_c     = '0;
        w_c[0]  = cin;
        for (int i = 0; i < SLICE; i++) begin
            w_sum[i]   = a[i] ^ w_b_eff[i] ^ w_c[i];
            w_c[i + 1] = (a[i] & w_b_eff[i]) | (w_c[i] & (a[i] ^ w_b_eff[i]));
        end
    end

    assign cout  = w_c[SLICE];
    assign c_msb = w_c[SLICE-1];

    always_comb begin
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_PASS_B: y = b;
            default:   y = w_sum;
        endcase
    end

endmodule

// File: rtl/alu_slice_seq.sv
// Slice-serial ALU: accepts one op, walks WIDTH/SLICE slices LSB-first through a
// single alu_slice with a registered carry, then presents result and flags.
module alu_slice_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [1:0]       o_dbg_state
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_k;
    logic             r_carry;
    logic             r_zero_acc;
    logic             r_cout;
    logic             r_zero;
    logic             r_ovf;

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_y_sl;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_last;
    logic             w_sl_zero;

    assign w_a_sl    = r_a[r_k*SLICE +: SLICE];
    assign w_b_sl    = r_b[r_k*SLICE +: SLICE];
    assign w_last    = (r_k == CW'(N - 1));
    assign w_sl_zero = (w_y_sl == '0);

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a     (w_a_sl),
        .b     (w_b_sl),
        .cin   (r_carry),
        .op    (r_op),
        .y     (w_y_sl),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; in_ready is high only in IDLE, out_valid only in DONE, and neither side
    // retracts its valid before the transfer edge.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= OP_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_k        <= '0;
            r_carry    <= 1'b0;
            r_zero_acc <= 1'b0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= op_e'(in_op);
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= init_carry(op_e'(in_op), in_cin);
                        r_k        <= '0;
                        r_zero_acc <= 1'b1;
                    end
                end
                RUN: begin
                    // CMP reports A as its result but its zero flag tracks the difference.
                    r_result[r_k*SLICE +: SLICE] <= (r_op == OP_CMP) ? w_a_sl : w_y_sl;
                    r_carry    <= w_cout;
                    r_zero_acc <= r_zero_acc & w_sl_zero;
                    if (w_last) begin
                        r_cout <= is_arith(r_op) & w_cout;
                        r_ovf  <= is_arith(r_op) & (w_c_msb ^ w_cout);
                        r_zero <= r_zero_acc & w_sl_zero;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_result  = r_result;
    assign out_cout    = r_cout;
    assign out_zero    = r_zero;
    assign out_ovf     = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: doc/alu_slice_seq.md
# alu_slice_seq

Parametrised, slice-serial successor to the 3-bit ALU PLA slice. One operation is accepted through a valid/ready handshake. A WIDTH-bit operand pair is then processed SLICE bits per cycle, least-significant slice first, with carry held in a register between slices. The result and flags are returned through a second valid/ready handshake. It sits between the operand register file and the writeback stage, and trades latency for area on wide datapaths.

## Interface

- WIDTH, default 16: operand and result width; must be a multiple of SLICE.
- SLICE, default 4: bits processed per cycle; N = WIDTH/SLICE slice steps per operation.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- in_op  in  3  opcode, defined in alu_pkg.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; used by ADC only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  result word.
- out_cout  out  1  carry out of the MSB. For SUB/CMP, 1 = no borrow.
- out_zero  out  1  out_result == 0. For CMP, this is the zero test on A−B.
- out_ovf  out  1  signed overflow for ADD/ADC/SUB/CMP; 0 otherwise.

## Operation

- Opcodes:
  - 000 ADD: A+B, cin=0.
  - 001 ADC: A+B+in_cin.
  - 010 SUB: A+~B, cin=1.
  - 011 CMP: flags as for SUB, out_result = A.
  - 100 AND.
  - 101 OR.
  - 110 XOR.
  - 111 PASS_B.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, latch op, A, B and initial carry; clear the slice counter; set zero_acc=1; go to RUN.
  - RUN: process slice k (bits k·SLICE..k·SLICE+SLICE−1) and write its result bits into the result register. Update carry_reg to the slice carry-out. zero_acc &= (slice result == 0), using the A−B difference for CMP. Increment k. When k = N−1, latch the final flags and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Overflow = carry into the MSB XOR carry out of the MSB, both taken from the last slice.
- Logic ops and PASS_B force out_cout=0 and out_ovf=0.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored, not queued.
- in_op/in_a/in_b/in_cin are sampled only on the accept edge; later changes have no effect.

## Timing

- Accept at edge T. RUN occupies cycles T+1..T+N. out_valid is high from cycle T+N+1 until the edge where out_ready is high.
- Latency: N+1 cycles. Throughput: one operation per N+2 cycles at most, since IDLE lasts one cycle after each DONE.
- out_result and all flags are stable throughout DONE. Under backpressure nothing changes.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_cout=0, out_zero=0, out_ovf=0, carry_reg=0, k=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No result is produced.
- SLICE=WIDTH (N=1) is legal and gives latency 2.
- The counter width is clog2(N), with a minimum of 1. There is no wrap past N−1.

## Structure

- alu_pkg holds:
  - the op_e enum (the 3-bit codes above);
  - the state_e enum (IDLE/RUN/DONE);
  - an is_arith(op) function.
- Sub-module alu_slice: combinational, SLICE wide.
  - Inputs: a, b, cin, op.
  - Outputs: y, cout, c_msb (carry into the slice MSB).
  - It performs B inversion for SUB/CMP internally.
- alu_slice_seq instantiates one alu_slice, feeds it through a slice mux selected by k, and holds the FSM, carry_reg, zero_acc and result register.

## Test plan

All scenarios use WIDTH=16, SLICE=4 unless stated.

- ADD 0x00FF+0x0001, accepted at T -> out_valid first at T+5; result 0x0100, cout=0, zero=0, ovf=0.
- ADD 0x7FFF+0x0001 -> 0x8000, ovf=1, cout=0.
- ADC 0xFFFF+0x0000 with cin=1 -> 0x0000, cout=1, zero=1, ovf=0.
- SUB 0x0005−0x0005 -> 0x0000, cout=1, zero=1. CMP 0x0003 vs 0x0005 -> result 0x0003, cout=0, zero=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second operation starts; the op accepted after release returns correctly.
- Reset at cycle T+2 of an XOR operation -> out_valid=0 and in_ready=1 immediately. Then SLICE=16 and AND 0xF0F0&0xFF00 -> 0xF000 at T+2.
